// File: rtl/uart_rx_drain_ctrl.sv
// UART receive-path sequencer: drains the RX FIFO onto a valid/ready byte stream and
// tracks occupancy for the watermark, idle-timeout and overrun interrupts.
module uart_rx_drain_ctrl #(
    parameter int DEPTH        = 16,
    parameter int LVL_W        = 5,
    parameter int TIMEOUT_BITS = 40,
    parameter int TO_W         = 6
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             clk_uart,
    input  logic             rx_done,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic [7:0]       fifo_q,
    output logic             fifo_rd_en,
    input  logic             drain_en,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    input  logic [LVL_W-1:0] wm_level,
    input  logic [2:0]       irq_en,
    input  logic [2:0]       irq_clr,
    output logic [LVL_W-1:0] level,
    output logic [2:0]       irq_status,
    output logic             irq
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LOAD,
        HOLD
    } state_t;

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_BITS - 1);
    localparam logic [TO_W-1:0]  TO_END  = TO_W'(TIMEOUT_BITS);

    state_t           state;
    logic             handshake;
    logic             rx_store;
    logic             rx_overrun;
    logic [LVL_W-1:0] level_next;
    logic [TO_W-1:0]  to_cnt;
    logic             to_clear;
    logic             to_fire;
    logic             to_sticky;
    logic             ovr_sticky;
    logic             wm_active;
    logic             unused_clr0;

    assign handshake  = dout_valid & dout_ready;
    assign rx_store   = rx_done & ~fifo_full;
    assign rx_overrun = rx_done & fifo_full;
    assign unused_clr0 = irq_clr[0];

    // A byte moving FIFO -> dout leaves the level untouched; only arrivals and consumer
    // handshakes change it, and simultaneous ones cancel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        level_next = level;
        if (rx_store && !handshake) begin
            if (level != LVL_MAX) level_next = level + LVL_W'(1);
        end else if (handshake && !rx_store) begin
            if (level != '0) level_next = level - LVL_W'(1);
        end
    end

    assign to_clear = rx_done | handshake | (level == '0);
    assign to_fire  = ~to_clear & clk_uart & (to_cnt == TO_LAST);

    assign wm_active  = (wm_level != '0) && (level >= wm_level);
    assign irq_status = {ovr_sticky, to_sticky, wm_active};

    // Drain sequencer: one FIFO read per byte, dout held stable until the handshake.
    always_ff @(posedge clk) begin
        // NOTE: all state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (drain_en && !fifo_empty && !dout_valid) begin
                        fifo_rd_en <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    state <= LOAD;
                end
                LOAD: begin
                    dout       <= fifo_q;
                    dout_valid <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (handshake) begin
                        dout_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Occupancy, idle timeout and interrupt stickies; a set event beats a clear pulse.
    always_ff @(posedge clk) begin
        if (RST) begin
            level      <= '0;
            to_cnt     <= '0;
            to_sticky  <= 1'b0;
            ovr_sticky <= 1'b0;
            irq        <= 1'b0;
        end else begin
            level <= level_next;

            // The counter parks at TIMEOUT_BITS so a cleared flag is not re-raised
            // until fresh silence follows new activity.
            if (to_clear) begin
                to_cnt <= '0;
            end else if (clk_uart && (to_cnt != TO_END)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            to_sticky  <= to_fire    | (to_sticky  & ~irq_clr[1]);
            ovr_sticky <= rx_overrun | (ovr_sticky & ~irq_clr[2]);
            irq        <= |(irq_status & irq_en);
        end
    end

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Bench for uart_rx_drain_ctrl: a small RX FIFO model feeds the DUT, a scoreboard queue
// holds the bytes expected on the stream, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_rx_drain_ctrl;

    localparam int LVL_W = 5;

    logic             clk = 1'b0;
    logic             RST;
    logic             clk_uart;
    logic             rx_done;
    logic [7:0]       rx_byte;
    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       fifo_q;
    logic             fifo_rd_en;
    logic             drain_en;
    logic [7:0]       dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [LVL_W-1:0] wm_level;
    logic [2:0]       irq_en;
    logic [2:0]       irq_clr;
    logic [LVL_W-1:0] level;
    logic [2:0]       irq_status;
    logic             irq;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int rd_cnt   = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_drain_ctrl #(
        .DEPTH(16), .LVL_W(LVL_W), .TIMEOUT_BITS(40), .TO_W(6)
    ) dut (
        .clk(clk), .RST(RST), .clk_uart(clk_uart), .rx_done(rx_done),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_q(fifo_q),
        .fifo_rd_en(fifo_rd_en), .drain_en(drain_en), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .wm_level(wm_level),
        .irq_en(irq_en), .irq_clr(irq_clr), .level(level),
        .irq_status(irq_status), .irq(irq)
    );

    // RX FIFO model: 8b x 16, registered q one cycle after the read request.
    logic [7:0] fmem [16];
    logic [3:0] wp, rp;
    logic [4:0] fcnt;

    assign fifo_empty = (fcnt == 5'd0);
    assign fifo_full  = (fcnt == 5'd16);

    always @(posedge clk) begin
        if (RST) begin
            wp     <= '0;
            rp     <= '0;
            fcnt   <= '0;
            fifo_q <= '0;
        end else begin
            if (rx_done && !fifo_full) begin
                fmem[wp] <= rx_byte;
                wp       <= wp + 4'd1;
            end
            if (fifo_rd_en && !fifo_empty) begin
                fifo_q <= fmem[rp];
                rp     <= rp + 4'd1;
            end
            if ((rx_done && !fifo_full) && !(fifo_rd_en && !fifo_empty))
                fcnt <= fcnt + 5'd1;
            else if (!(rx_done && !fifo_full) && (fifo_rd_en && !fifo_empty))
                fcnt <= fcnt - 5'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: stream scoreboard plus read-pulse, latency and stability properties.
    logic       rd_d1 = 1'b0, rd_d2 = 1'b0, valid_prev = 1'b0, hs_prev = 1'b0;
    logic [7:0] dout_prev = '0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (RST) begin
            rd_d1 = 1'b0; rd_d2 = 1'b0; valid_prev = 1'b0; hs_prev = 1'b0; dout_prev = '0;
        end else begin
            if (fifo_rd_en) begin
                rd_cnt++;
                check("rd_en_single_cycle", 32'(rd_d1), 32'd0);
            end
            if (dout_valid && !valid_prev)
                check("rd_to_valid_latency", 32'(rd_d2), 32'd1);
            if (dout_valid && valid_prev && !hs_prev)
                check("dout_stable", 32'(dout), 32'(dout_prev));
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte (t=%0t)", dout, $time);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("stream_byte", 32'(dout), 32'(exp_b));
                end
                n_pops++;
            end
            rd_d2      = rd_d1;
            rd_d1      = fifo_rd_en;
            valid_prev = dout_valid;
            hs_prev    = dout_valid && dout_ready;
            dout_prev  = dout;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_done = 1'b1;
        rx_byte = b;
        if (!fifo_full) exp_q.push_back(b);
        step();
        rx_done = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            clk_uart = 1'b1;
            step();
            clk_uart = 1'b0;
            step();
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k = 0;
        while (n_pops < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("pops_within_budget", 32'(n_pops >= target), 32'd1);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!dout_valid && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("valid_within_budget", 32'(dout_valid), 32'd1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    int base;

    initial begin
        RST = 1'b1; clk_uart = 1'b0; rx_done = 1'b0; rx_byte = '0; drain_en = 1'b0;
        dout_ready = 1'b0; wm_level = '0; irq_en = '0; irq_clr = '0;
        step();
        step();
        RST = 1'b0;

        // 1: idle with an empty FIFO: no reads, every output at zero.
        drain_en = 1'b1;
        @(negedge clk);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_irq_status", 32'(irq_status), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        repeat (100) step();
        check("idle_no_reads", 32'(rd_cnt), 32'd0);
        check("idle_level", 32'(level), 32'd0);

        // 2: two bytes straight through with the consumer always ready.
        dout_ready = 1'b1;
        base = n_pops;
        push(8'hA5);
        push(8'h3C);
        @(negedge clk);
        check("t2_level_2", 32'(level), 32'd2);
        wait_pops(base + 1, 40);
        @(negedge clk);
        check("t2_level_1", 32'(level), 32'd1);
        wait_pops(base + 2, 40);
        @(negedge clk);
        check("t2_level_0", 32'(level), 32'd0);
        check("t2_reads", 32'(rd_cnt), 32'd2);

        // 3: stalled consumer, watermark at 3 bytes.
        dout_ready = 1'b0;
        wm_level   = 5'd3;
        irq_en     = 3'b001;
        base       = rd_cnt;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        @(negedge clk);
        check("t3_level_3", 32'(level), 32'd3);
        check("t3_wm_active", 32'(irq_status[0]), 32'd1);
        check("t3_irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk);
        check("t3_irq_next_cycle", 32'(irq), 32'd1);
        repeat (10) step();
        check("t3_one_read", 32'(rd_cnt - base), 32'd1);
        check("t3_dout_held", 32'(dout), 32'h11);
        check("t3_dout_valid", 32'(dout_valid), 32'd1);
        wm_level = 5'd4;
        @(negedge clk);
        check("t3_wm_below", 32'(irq_status[0]), 32'd0);
        wm_level = 5'd0;
        @(negedge clk);
        check("t3_wm_disabled", 32'(irq_status[0]), 32'd0);
        wm_level = 5'd3;
        base = n_pops;
        step();
        dout_ready = 1'b1;
        wait_pops(base + 3, 60);
        @(negedge clk);
        check("t3_drained_level", 32'(level), 32'd0);
        check("t3_wm_cleared", 32'(irq_status[0]), 32'd0);

        // 5: overrun on a full FIFO, clear racing a new overrun.
        step();
        do_reset();
        drain_en = 1'b0; dout_ready = 1'b0; wm_level = '0; irq_en = 3'b100;
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        @(negedge clk);
        check("t5_level_full", 32'(level), 32'd16);
        check("t5_no_ovr_yet", 32'(irq_status[2]), 32'd0);
        step();
        push(8'hEE);
        @(negedge clk);
        check("t5_ovr_set", 32'(irq_status[2]), 32'd1);
        check("t5_level_unchanged", 32'(level), 32'd16);
        check("t5_irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk);
        check("t5_irq", 32'(irq), 32'd1);
        step();
        irq_clr = 3'b100;
        push(8'hEF);
        irq_clr = 3'b000;
        @(negedge clk);
        check("t5_set_beats_clr", 32'(irq_status[2]), 32'd1);
        step();
        irq_clr = 3'b100;
        step();
        irq_clr = 3'b000;
        @(negedge clk);
        check("t5_ovr_cleared", 32'(irq_status[2]), 32'd0);
        step();
        base = n_pops;
        drain_en = 1'b1; dout_ready = 1'b1;
        wait_pops(base + 16, 200);
        @(negedge clk);
        check("t5_drained_level", 32'(level), 32'd0);

        // 4: idle timeout with bytes held back, then restart by a mid-count arrival.
        step();
        do_reset();
        drain_en = 1'b0; dout_ready = 1'b0; irq_en = 3'b010;
        push(8'h41);
        ticks(39);
        @(negedge clk);
        check("t4_no_flag_39", 32'(irq_status[1]), 32'd0);
        step();
        ticks(1);
        @(negedge clk);
        check("t4_flag_40", 32'(irq_status[1]), 32'd1);
        check("t4_irq", 32'(irq), 32'd1);
        step();
        irq_clr = 3'b010;
        step();
        irq_clr = 3'b000;
        @(negedge clk);
        check("t4_flag_cleared", 32'(irq_status[1]), 32'd0);
        step();
        push(8'h42);
        ticks(38);
        clk_uart = 1'b1;
        push(8'h43);
        clk_uart = 1'b0;
        ticks(39);
        @(negedge clk);
        check("t4_restart_no_flag", 32'(irq_status[1]), 32'd0);
        step();
        ticks(1);
        @(negedge clk);
        check("t4_restart_flag", 32'(irq_status[1]), 32'd1);

        // 6: reset while a byte is held on dout.
        step();
        drain_en = 1'b1;
        wait_valid(20);
        @(negedge clk);
        check("t6_level_before", 32'(level), 32'd3);
        step();
        do_reset();
        @(negedge clk);
        check("t6_dout_valid", 32'(dout_valid), 32'd0);
        check("t6_dout", 32'(dout), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_irq_status", 32'(irq_status), 32'd0);
        check("t6_rd_en", 32'(fifo_rd_en), 32'd0);
        step();
        dout_ready = 1'b1;
        base = n_pops;
        push(8'h5A);
        wait_pops(base + 1, 40);
        @(negedge clk);
        check("t6_after_level", 32'(level), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
